// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ==== mips_cpu_pkg : shared widths and writeback request type (rev 1.0) ====
package mips_cpu_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  // idx occupies the MSBs so FIFOs can tap it as the entry key
  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/mips_cpu_wb_arbiter_if.sv
`default_nettype none
// ==== mips_cpu_wb_arbiter_if : writeback arbiter bus bundle (rev 1.0) ====
interface mips_cpu_wb_arbiter_if;
  import mips_cpu_pkg::*;

  logic                 alu_valid;
  logic                 alu_ready;
  logic [REG_IDX_W-1:0] alu_index;
  logic [DATA_W-1:0]    alu_data;
  logic                 ld_issue;
  logic                 ld_issue_ready;
  logic [REG_IDX_W-1:0] ld_issue_index;
  logic                 ld_resp_valid;
  logic [DATA_W-1:0]    ld_resp_data;
  logic [REG_IDX_W-1:0] read_index_rs;
  logic [REG_IDX_W-1:0] read_index_rt;
  logic                 hazard_rs;
  logic                 hazard_rt;
  logic [REG_IDX_W-1:0] write_index;
  logic                 write_enable;
  logic [DATA_W-1:0]    write_data;
  logic                 resp_err;

  modport slave (
    input  alu_valid, alu_index, alu_data, ld_issue, ld_issue_index,
           ld_resp_valid, ld_resp_data, read_index_rs, read_index_rt,
    output alu_ready, ld_issue_ready, hazard_rs, hazard_rt,
           write_index, write_enable, write_data, resp_err
  );

  modport master (
    output alu_valid, alu_index, alu_data, ld_issue, ld_issue_index,
           ld_resp_valid, ld_resp_data, read_index_rs, read_index_rt,
    input  alu_ready, ld_issue_ready, hazard_rs, hazard_rt,
           write_index, write_enable, write_data, resp_err
  );

endinterface
`default_nettype wire

// File: rtl/mips_cpu_wb_fifo.sv
`default_nettype none
// ==== mips_cpu_wb_fifo : synchronous FIFO exposing per-entry key/valid taps (rev 1.0) ====
module mips_cpu_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int KEY_W = WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0][KEY_W-1:0]  entry_key,
  output logic [DEPTH-1:0]             entry_valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [PTR_W:0]              r_count;
  logic                        w_do_push;
  logic                        w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign head      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  // A slot is live when its distance from the read pointer is below the fill count
  for (genvar i = 0; i < DEPTH; i++) begin : g_tap
    logic [PTR_W-1:0] w_offset;
    assign w_offset       = PTR_W'(i) - r_rd_ptr;
    assign entry_valid[i] = ({1'b0, w_offset} < r_count);
    assign entry_key[i]   = r_mem[i][WIDTH-1 -: KEY_W];
  end

endmodule
`default_nettype wire

// File: rtl/mips_cpu_wb_arbiter.sv
`default_nettype none
// ==== mips_cpu_wb_arbiter : register-file write port arbiter, loads over ALU (rev 1.0) ====
module mips_cpu_wb_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int ALU_DEPTH = 2,
  parameter int LD_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_cpu_wb_arbiter_if.slave bus
);

  localparam int WB_W = $bits(wb_req_t);

  wb_req_t                            w_alu_req;
  wb_req_t                            w_alu_head;
  wb_req_t                            w_sel;
  logic [ALU_DEPTH-1:0][REG_IDX_W-1:0] w_alu_keys;
  logic [ALU_DEPTH-1:0]               w_alu_vld;
  logic [REG_IDX_W-1:0]               w_tag_head;
  logic [LD_DEPTH-1:0][REG_IDX_W-1:0] w_tag_keys;
  logic [LD_DEPTH-1:0]                w_tag_vld;
  logic w_alu_full, w_alu_empty, w_tag_full, w_tag_empty;
  logic w_alu_ready, w_alu_acc, w_alu_push, w_alu_pop;
  logic w_ld_ready, w_tag_push, w_tag_pop;
  logic w_waw, w_sel_valid, w_err_set;
  logic                 r_we;
  logic                 r_err;
  logic [REG_IDX_W-1:0] r_idx;
  logic [DATA_W-1:0]    r_data;

  function automatic logic pending(
    input logic [REG_IDX_W-1:0]               idx,
    input logic [LD_DEPTH-1:0][REG_IDX_W-1:0]  tags,
    input logic [LD_DEPTH-1:0]                 tag_vld,
    input logic [ALU_DEPTH-1:0][REG_IDX_W-1:0] alus,
    input logic [ALU_DEPTH-1:0]                alu_vld,
    input logic                                we,
    input logic [REG_IDX_W-1:0]                widx
  );
    logic hit;
    hit = we && (widx == idx);
    for (int i = 0; i < LD_DEPTH; i++)  hit |= tag_vld[i] && (tags[i] == idx);
    for (int i = 0; i < ALU_DEPTH; i++) hit |= alu_vld[i] && (alus[i] == idx);
    return hit && (idx != REG_ZERO);
  endfunction

  assign w_alu_req = '{idx: bus.alu_index, data: bus.alu_data};

  mips_cpu_wb_fifo #(.WIDTH(WB_W), .DEPTH(ALU_DEPTH), .KEY_W(REG_IDX_W)) u_alu_q (
    .clk(clk), .reset(reset), .push(w_alu_push), .push_data(w_alu_req), .pop(w_alu_pop),
    .head(w_alu_head), .full(w_alu_full), .empty(w_alu_empty),
    .entry_key(w_alu_keys), .entry_valid(w_alu_vld)
  );

  mips_cpu_wb_fifo #(.WIDTH(REG_IDX_W), .DEPTH(LD_DEPTH), .KEY_W(REG_IDX_W)) u_tag_q (
    .clk(clk), .reset(reset), .push(w_tag_push), .push_data(bus.ld_issue_index), .pop(w_tag_pop),
    .head(w_tag_head), .full(w_tag_full), .empty(w_tag_empty),
    .entry_key(w_tag_keys), .entry_valid(w_tag_vld)
  );

  // An ALU write may not overtake an older in-flight load to the same register
  always_comb begin
    w_waw = 1'b0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (w_tag_vld[i] && (w_tag_keys[i] == bus.alu_index)) w_waw = 1'b1;
    end
    if (bus.alu_index == REG_ZERO) w_waw = 1'b0;
  end

  assign w_alu_ready = !reset && !w_alu_full && !w_waw;
  assign w_ld_ready  = !reset && !w_tag_full;
  assign w_alu_acc   = bus.alu_valid && w_alu_ready;
  assign w_tag_push  = bus.ld_issue && w_ld_ready;

  always_comb begin
    w_tag_pop   = 1'b0;
    w_alu_pop   = 1'b0;
    w_alu_push  = 1'b0;
    w_sel_valid = 1'b0;
    w_sel       = '0;
    if (bus.ld_resp_valid && !w_tag_empty) begin
      w_tag_pop   = 1'b1;
      w_sel_valid = 1'b1;
      w_sel       = '{idx: w_tag_head, data: bus.ld_resp_data};
      w_alu_push  = w_alu_acc;
    end else if (!w_alu_empty) begin
      w_alu_pop   = 1'b1;
      w_sel_valid = 1'b1;
      w_sel       = w_alu_head;
      w_alu_push  = w_alu_acc;
    end else if (w_alu_acc) begin
      w_sel_valid = 1'b1;
      w_sel       = w_alu_req;
    end
  end

  assign w_err_set = bus.ld_resp_valid && w_tag_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_idx  <= REG_ZERO;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      r_we   <= w_sel_valid && (w_sel.idx != REG_ZERO);
      r_idx  <= w_sel_valid ? w_sel.idx : REG_ZERO;
      r_data <= w_sel_valid ? w_sel.data : '0;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign bus.alu_ready      = w_alu_ready;
  assign bus.ld_issue_ready = w_ld_ready;
  assign bus.write_enable   = r_we;
  assign bus.write_index    = r_idx;
  assign bus.write_data     = r_data;
  assign bus.resp_err       = r_err;
  assign bus.hazard_rs = !reset && pending(bus.read_index_rs, w_tag_keys, w_tag_vld,
                                           w_alu_keys, w_alu_vld, r_we, r_idx);
  assign bus.hazard_rt = !reset && pending(bus.read_index_rt, w_tag_keys, w_tag_vld,
                                           w_alu_keys, w_alu_vld, r_we, r_idx);

endmodule
`default_nettype wire
